credit_link_tx: RTL
===================

Name: credit_link_tx

Overview:
- Drain stage that sits directly downstream of a router's show-ahead input/output FIFO.
- Pops flits from the FIFO and drives them onto an inter-router link, one per cycle through a registered output.
- Tracks free slots in the remote receive buffer with a credit counter.
- Tracks packet framing with a two-state FSM and flags protocol and credit errors.

Parameters:
- FLIT_W, 64, flit width in bits; bit FLIT_W-1 = tail flag, bit FLIT_W-2 = head flag.
- CREDIT_MAX, 7, remote buffer usable slots (remote depth minus 1); credit counter reset value.
- CNT_W, $clog2(CREDIT_MAX+1), credit counter width (localparam, derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fifo_q  in  FLIT_W  head-of-FIFO flit (show-ahead, valid when fifo_empty=0)
- fifo_empty  in  1  FIFO empty
- fifo_consume  out  1  pop strobe to FIFO (combinational)
- link_data  out  FLIT_W  registered flit to link
- link_valid  out  1  link_data valid this cycle
- credit_in  in  1  remote returned one slot (one pulse = one credit)
- credit_count  out  CNT_W  current credits
- pkt_active  out  1  FSM in PKT state
- proto_err  out  1  sticky framing error
- credit_err  out  1  sticky credit overflow

Behaviour:
- Reset values: link_data=0, link_valid=0, credit_count=CREDIT_MAX, FSM=IDLE, pkt_active=0, proto_err=0, credit_err=0.
- Send condition:
  - send = ~fifo_empty & (credit_count != 0) & ~rst.
  - fifo_consume = send, combinational.
  - Uses the registered credit_count only; a credit_in arriving in the same cycle does not enable a send that cycle.
- Output latency: 1 cycle. On a send cycle, link_data<=fifo_q and link_valid<=1 at the next edge. Otherwise link_valid<=0 and link_data holds its previous value.
- Credit arithmetic: next = credit_count - send + credit_in.
  - Simultaneous send and credit_in: count unchanged.
  - credit_in with count==CREDIT_MAX and no send: count saturates at CREDIT_MAX and credit_err<=1.
  - Underflow is impossible because send requires count>0.
- FSM (evaluated only on send cycles; let h = head flag, t = tail flag of fifo_q):
  - IDLE, h&~t: -> PKT.
  - IDLE, h&t: single-flit packet, stay IDLE.
  - IDLE, ~h: proto_err<=1, stay IDLE; the flit is still sent.
  - PKT, t&~h: -> IDLE.
  - PKT, h: proto_err<=1. Next state is PKT if ~t, IDLE if t.
  - PKT, ~h&~t: body flit, stay PKT.
- pkt_active = (state==PKT).
- Error flags clear only on rst.
- Reset mid-packet: FSM->IDLE, credits->CREDIT_MAX, link_valid=0 the cycle after rst samples high. No consume while rst is high.
- Back-to-back: with credits available and the FIFO non-empty, one flit per cycle and link_valid stays high continuously.

Optional Feature:
- Macro: CREDIT_LINK_STATS_EN.
- Defined: adds outputs flit_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - flit_cnt increments on every send, wrapping at 2^32.
  - stall_cnt increments on cycles where ~fifo_empty & credit_count==0, wrapping.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package router_pkg:
  - localparams FLIT_TAIL_BIT, FLIT_HEAD_BIT (as offsets from FLIT_W-1).
  - enum link_state_t {LINK_IDLE, LINK_PKT}.
  - function flit_is_head(), flit_is_tail().
- One sub-module: credit_counter (saturating up/down counter with overflow flag, parameterised by MAX), reusable for the receive side.

Test Plan:
- Reset, then push 3 flits (head, body, tail) into the FIFO with CREDIT_MAX=7 -> fifo_consume high 3 consecutive cycles; link_valid high on cycles 1-3 after; credit_count 7->4; pkt_active high for exactly 2 cycles; proto_err=0.
- Keep FIFO full, no credit_in -> exactly 7 flits sent, then fifo_consume=0 and credit_count=0. Pulse credit_in once -> one more flit sent; count returns to 0.
- credit_count=0 and credit_in pulse in the same cycle the FIFO is non-empty -> no send that cycle; send the next cycle.
- Send and credit_in in the same cycle at count=4 -> count stays 4.
- Body flit as first flit after reset -> proto_err=1, flit still appears on link_data. Two heads back-to-back without a tail -> proto_err=1.
- Idle at CREDIT_MAX, pulse credit_in -> credit_err=1, count stays 7. Assert rst mid-packet -> all outputs return to reset values the next cycle. With CREDIT_LINK_STATS_EN defined, 10 flits plus 5 credit-stalled cycles -> flit_cnt=10, stall_cnt=5.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: flit control-bit layout, link framing states and flag helpers.
package router_pkg;

    // Control bits sit at the top of a flit; offsets count down from FLIT_W-1.
    localparam int unsigned FLIT_TAIL_BIT = 0;
    localparam int unsigned FLIT_HEAD_BIT = 1;
    localparam int unsigned FLIT_CTL_W    = 2;

    typedef enum logic [0:0] {
        LINK_IDLE = 1'b0,
        LINK_PKT  = 1'b1
    } link_state_t;

    // ctl is flit[FLIT_W-1 -: FLIT_CTL_W]; shifting by the offset lands the flag on the MSB.
    function automatic logic flit_is_head(input logic [FLIT_CTL_W-1:0] ctl);
        logic [FLIT_CTL_W-1:0] sh;
        sh = ctl << FLIT_HEAD_BIT;
        return sh[FLIT_CTL_W-1];
    endfunction

    function automatic logic flit_is_tail(input logic [FLIT_CTL_W-1:0] ctl);
        logic [FLIT_CTL_W-1:0] sh;
        sh = ctl << FLIT_TAIL_BIT;
        return sh[FLIT_CTL_W-1];
    endfunction

endpackage

// File: rtl/credit_link_tx_if.sv
// FIFO-drain and link-side signals of the credit-based link transmitter.
interface credit_link_tx_if #(
    parameter int unsigned FLIT_W = 64
);
    logic [FLIT_W-1:0] fifo_q;
    logic              fifo_empty;
    logic              fifo_consume;
    logic [FLIT_W-1:0] link_data;
    logic              link_valid;
    logic              credit_in;

    modport master (
        input  fifo_q, fifo_empty, credit_in,
        output fifo_consume, link_data, link_valid
    );

    modport slave (
        output fifo_q, fifo_empty, credit_in,
        input  fifo_consume, link_data, link_valid
    );
endinterface

// File: rtl/credit_link_tx_credit_counter.sv
// Saturating up/down credit counter with sticky overflow flag; resets full (MAX).
module credit_counter #(
    parameter  int unsigned MAX = 7,
    localparam int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         overflow
);

    // Simultaneous dec and inc cancel; inc at MAX saturates and flags overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= W'(MAX);
            overflow <= 1'b0;
        end else begin
            case ({dec, inc})
                2'b10: begin
                    if (count != '0) count <= count - W'(1);
                end
                2'b01: begin
                    if (count == W'(MAX)) overflow <= 1'b1;
                    else                  count    <= count + W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/credit_link_tx.sv
// Drains a show-ahead FIFO onto a credit-controlled link and tracks packet framing.
// Optional CREDIT_LINK_STATS_EN adds flit_cnt / stall_cnt statistics outputs.
module credit_link_tx
    import router_pkg::*;
#(
    parameter  int unsigned FLIT_W     = 64,
    parameter  int unsigned CREDIT_MAX = 7,
    localparam int unsigned CNT_W      = $clog2(CREDIT_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    credit_link_tx_if.master  link,
    output logic [CNT_W-1:0]  credit_count,
    output logic              pkt_active,
    output logic              proto_err,
    output logic              credit_err
`ifdef CREDIT_LINK_STATS_EN
    ,
    output logic [31:0]       flit_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic                  send;
    logic [FLIT_CTL_W-1:0] ctl;
    logic                  head;
    logic                  tail;
    logic                  proto_err_set;
    link_state_t           state;
    link_state_t           state_nxt;

    // Only the registered count gates a send; a same-cycle credit waits a cycle.
    assign send              = ~link.fifo_empty & (credit_count != '0) & ~rst;
    assign link.fifo_consume = send;

    assign ctl  = link.fifo_q[FLIT_W-1 -: FLIT_CTL_W];
    assign head = flit_is_head(ctl);
    assign tail = flit_is_tail(ctl);

    always_ff @(posedge clk) begin
        if (rst) begin
            link.link_data  <= '0;
            link.link_valid <= 1'b0;
        end else begin
            link.link_valid <= send;
            if (send) link.link_data <= link.fifo_q;
        end
    end

    credit_counter #(.MAX(CREDIT_MAX)) u_credit (
        .clk      (clk),
        .rst      (rst),
        .dec      (send),
        .inc      (link.credit_in),
        .count    (credit_count),
        .overflow (credit_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LINK_IDLE;
        else     state <= state_nxt;
    end

    // Framing advances only on flits actually sent; malformed flits still go out.
    always_comb begin
        state_nxt     = state;
        proto_err_set = 1'b0;
        if (send) begin
            case (state)
                LINK_IDLE: begin
                    if (!head)      proto_err_set = 1'b1;
                    else if (!tail) state_nxt     = LINK_PKT;
                end
                LINK_PKT: begin
                    if (head) begin
                        proto_err_set = 1'b1;
                        state_nxt     = tail ? LINK_IDLE : LINK_PKT;
                    end else if (tail) begin
                        state_nxt = LINK_IDLE;
                    end
                end
                default: state_nxt = LINK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                proto_err <= 1'b0;
        else if (proto_err_set) proto_err <= 1'b1;
    end

    assign pkt_active = (state == LINK_PKT);

`ifdef CREDIT_LINK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (send) flit_cnt <= flit_cnt + 32'd1;
            if (~link.fifo_empty && credit_count == '0) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
